// File: rtl/xcorr_peak_engine.sv
// Frame-based complex cross-correlator over NUM_LAGS lags with L1 peak search.
// Optional macro XCORR_SATURATE_EN: saturating (sticky) accumulators instead of wrapping ones.
module xcorr_peak_engine #(
  parameter int DATA_W   = 16,
  parameter int NUM_LAGS = 8,
  parameter int ACC_W    = 40,
  parameter int LEN_W    = 16,
  parameter int IDX_W    = $clog2(NUM_LAGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [LEN_W-1:0]         i_frame_len,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic signed [DATA_W-1:0] i_x1_re,
  input  logic signed [DATA_W-1:0] i_x1_im,
  input  logic signed [DATA_W-1:0] i_x2_re,
  input  logic signed [DATA_W-1:0] i_x2_im,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [IDX_W-1:0]         o_peak_index,
  output logic [ACC_W:0]           o_peak_mag,
  input  logic [IDX_W-1:0]         i_rd_lag,
  output logic signed [ACC_W-1:0]  o_rd_re,
  output logic signed [ACC_W-1:0]  o_rd_im
);

  // state  | meaning
  // IDLE   | waiting for start
  // ACCUM  | accepting samples, products and accumulation pipelined
  // DRAIN  | last registered product lands in the accumulators
  // SEARCH | one lag per cycle, strict-greater keeps the lowest tying index
  // DONE   | publish peak, pulse done, drop busy
  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN, S_SEARCH, S_DONE} state_t;

  localparam int PROD_W = 2*DATA_W + 1;
  localparam int TAB_N  = 1 << IDX_W;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t r_state, w_next;

  logic signed [DATA_W-1:0] r_dl_re [NUM_LAGS-1];
  logic signed [DATA_W-1:0] r_dl_im [NUM_LAGS-1];
  logic signed [DATA_W-1:0] w_tap_re [NUM_LAGS];
  logic signed [DATA_W-1:0] w_tap_im [NUM_LAGS];
  logic signed [PROD_W-1:0] r_p_re [NUM_LAGS];
  logic signed [PROD_W-1:0] r_p_im [NUM_LAGS];
  logic signed [ACC_W-1:0]  w_tab_re [TAB_N];
  logic signed [ACC_W-1:0]  w_tab_im [TAB_N];
  logic                     r_p_v;
  logic [LEN_W-1:0]         r_cnt;
  logic [IDX_W-1:0]         r_scan, r_max_idx, r_peak_index;
  logic [ACC_W:0]           r_max, r_peak_mag, w_mag;
  logic                     r_busy, r_done;
  logic signed [ACC_W-1:0]  r_rd_re, r_rd_im;
  logic                     w_go, w_accept, w_last, w_scan_end;

  function automatic logic signed [PROD_W-1:0] cmul_re(input logic signed [DATA_W-1:0] a, b, c, d);
    logic signed [PROD_W-1:0] ea, eb, ec, ed;
    ea = a; eb = b; ec = c; ed = d;
    return ea*ec + eb*ed;
  endfunction

  function automatic logic signed [PROD_W-1:0] cmul_im(input logic signed [DATA_W-1:0] a, b, c, d);
    logic signed [PROD_W-1:0] ea, eb, ec, ed;
    ea = a; eb = b; ec = c; ed = d;
    return eb*ec - ea*ed;
  endfunction

  // widened before negation so the most negative accumulator value has a magnitude
  function automatic logic [ACC_W:0] abs_x(input logic signed [ACC_W-1:0] v);
    logic [ACC_W:0] e;
    e = {v[ACC_W-1], v};
    return v[ACC_W-1] ? (~e + 1'b1) : e;
  endfunction

  always_comb begin
    w_tap_re[0] = i_x1_re;
    w_tap_im[0] = i_x1_im;
    for (int k = 1; k < NUM_LAGS; k++) begin
      w_tap_re[k] = r_dl_re[k-1];
      w_tap_im[k] = r_dl_im[k-1];
    end
  end

  assign w_last     = w_accept && (r_cnt == LEN_W'(1));
  assign w_scan_end = (r_scan == IDX_W'(NUM_LAGS-1));
  assign w_mag      = abs_x(w_tab_re[r_scan]) + abs_x(w_tab_im[r_scan]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_go     = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_go   = 1'b1;
        w_next = (i_frame_len == '0) ? S_SEARCH : S_ACCUM;
      end
      S_ACCUM: begin
        w_accept = i_in_valid;
        if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN:  w_next = S_SEARCH;
      S_SEARCH: if (w_scan_end) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_LAGS-1; k++) begin
        r_dl_re[k] <= '0;
        r_dl_im[k] <= '0;
      end
      for (int k = 0; k < NUM_LAGS; k++) begin
        r_p_re[k] <= '0;
        r_p_im[k] <= '0;
      end
      r_p_v        <= 1'b0;
      r_cnt        <= '0;
      r_scan       <= '0;
      r_max        <= '0;
      r_max_idx    <= '0;
      r_peak_index <= '0;
      r_peak_mag   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rd_re      <= '0;
      r_rd_im      <= '0;
    end else begin
      r_done  <= 1'b0;
      r_p_v   <= w_accept;
      r_rd_re <= w_tab_re[i_rd_lag];
      r_rd_im <= w_tab_im[i_rd_lag];
      if (w_go) begin
        for (int k = 0; k < NUM_LAGS-1; k++) begin
          r_dl_re[k] <= '0;
          r_dl_im[k] <= '0;
        end
        r_cnt     <= i_frame_len;
        r_busy    <= 1'b1;
        r_scan    <= '0;
        r_max     <= '0;
        r_max_idx <= '0;
      end
      if (w_accept) begin
        r_dl_re[0] <= i_x1_re;
        r_dl_im[0] <= i_x1_im;
        for (int k = 1; k < NUM_LAGS-1; k++) begin
          r_dl_re[k] <= r_dl_re[k-1];
          r_dl_im[k] <= r_dl_im[k-1];
        end
        for (int k = 0; k < NUM_LAGS; k++) begin
          r_p_re[k] <= cmul_re(w_tap_re[k], w_tap_im[k], i_x2_re, i_x2_im);
          r_p_im[k] <= cmul_im(w_tap_re[k], w_tap_im[k], i_x2_re, i_x2_im);
        end
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == S_SEARCH) begin
        if (w_mag > r_max) begin
          r_max     <= w_mag;
          r_max_idx <= r_scan;
        end
        r_scan <= r_scan + 1'b1;
      end
      if (r_state == S_DONE) begin
        r_peak_index <= r_max_idx;
        r_peak_mag   <= r_max;
        r_done       <= 1'b1;
        r_busy       <= 1'b0;
      end
    end
  end

  // table padded to a power of two so readback/search of an unused lag reads 0
  for (genvar g = 0; g < TAB_N; g++) begin : g_lag
    if (g < NUM_LAGS) begin : g_acc
      logic signed [ACC_W-1:0] r_acc_re, r_acc_im, w_pe_re, w_pe_im;
      assign w_pe_re = ACC_W'(r_p_re[g]);
      assign w_pe_im = ACC_W'(r_p_im[g]);
`ifdef XCORR_SATURATE_EN
      logic signed [ACC_W:0] w_s_re, w_s_im;
      logic                  r_sat_re, r_sat_im;
      assign w_s_re = {r_acc_re[ACC_W-1], r_acc_re} + {w_pe_re[ACC_W-1], w_pe_re};
      assign w_s_im = {r_acc_im[ACC_W-1], r_acc_im} + {w_pe_im[ACC_W-1], w_pe_im};
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_acc_re <= '0;
          r_acc_im <= '0;
          r_sat_re <= 1'b0;
          r_sat_im <= 1'b0;
        end else if (w_go) begin
          r_acc_re <= '0;
          r_acc_im <= '0;
          r_sat_re <= 1'b0;
          r_sat_im <= 1'b0;
        end else if (r_p_v) begin
          if (!r_sat_re) begin
            if (w_s_re[ACC_W] != w_s_re[ACC_W-1]) begin
              r_sat_re <= 1'b1;
              r_acc_re <= w_s_re[ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
              r_acc_re <= w_s_re[ACC_W-1:0];
            end
          end
          if (!r_sat_im) begin
            if (w_s_im[ACC_W] != w_s_im[ACC_W-1]) begin
              r_sat_im <= 1'b1;
              r_acc_im <= w_s_im[ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
              r_acc_im <= w_s_im[ACC_W-1:0];
            end
          end
        end
      end
`else
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_acc_re <= '0;
          r_acc_im <= '0;
        end else if (w_go) begin
          r_acc_re <= '0;
          r_acc_im <= '0;
        end else if (r_p_v) begin
          r_acc_re <= r_acc_re + w_pe_re;
          r_acc_im <= r_acc_im + w_pe_im;
        end
      end
`endif
      assign w_tab_re[g] = r_acc_re;
      assign w_tab_im[g] = r_acc_im;
    end else begin : g_pad
      assign w_tab_re[g] = '0;
      assign w_tab_im[g] = '0;
    end
  end

  assign o_in_ready   = (r_state == S_ACCUM);
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_peak_index = r_peak_index;
  assign o_peak_mag   = r_peak_mag;
  assign o_rd_re      = r_rd_re;
  assign o_rd_im      = r_rd_im;

endmodule

// File: tb/tb_xcorr_peak_engine.sv
// Randomized self-checking bench for xcorr_peak_engine against a direct sum-of-products model.
module tb_xcorr_peak_engine;
  localparam int DW = 16, NL = 8, AW = 40, LW = 16, IW = 3;
  localparam int SDW = 8, SAW = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 i_start = 1'b0, i_in_valid = 1'b0;
  logic [LW-1:0]        i_frame_len = '0;
  logic signed [DW-1:0] i_x1_re = '0, i_x1_im = '0, i_x2_re = '0, i_x2_im = '0;
  logic [IW-1:0]        i_rd_lag = '0;
  logic                 o_in_ready, o_busy, o_done;
  logic [IW-1:0]        o_peak_index;
  logic [AW:0]          o_peak_mag;
  logic signed [AW-1:0] o_rd_re, o_rd_im;

  logic                  s_start = 1'b0, s_in_valid = 1'b0;
  logic [LW-1:0]         s_frame_len = '0;
  logic signed [SDW-1:0] s_x1_re = '0, s_x1_im = '0, s_x2_re = '0, s_x2_im = '0;
  logic [IW-1:0]         s_rd_lag = '0;
  logic                  s_in_ready, s_busy, s_done;
  logic [IW-1:0]         s_peak_index;
  logic [SAW:0]          s_peak_mag;
  logic signed [SAW-1:0] s_rd_re, s_rd_im;

  xcorr_peak_engine #(.DATA_W(DW), .NUM_LAGS(NL), .ACC_W(AW), .LEN_W(LW)) u_dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_frame_len(i_frame_len),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_x1_re(i_x1_re), .i_x1_im(i_x1_im), .i_x2_re(i_x2_re), .i_x2_im(i_x2_im),
    .o_busy(o_busy), .o_done(o_done), .o_peak_index(o_peak_index), .o_peak_mag(o_peak_mag),
    .i_rd_lag(i_rd_lag), .o_rd_re(o_rd_re), .o_rd_im(o_rd_im));

  xcorr_peak_engine #(.DATA_W(SDW), .NUM_LAGS(NL), .ACC_W(SAW), .LEN_W(LW)) u_dut_s (
    .clk(clk), .rst(rst), .i_start(s_start), .i_frame_len(s_frame_len),
    .i_in_valid(s_in_valid), .o_in_ready(s_in_ready),
    .i_x1_re(s_x1_re), .i_x1_im(s_x1_im), .i_x2_re(s_x2_re), .i_x2_im(s_x2_im),
    .o_busy(s_busy), .o_done(s_done), .o_peak_index(s_peak_index), .o_peak_mag(s_peak_mag),
    .i_rd_lag(s_rd_lag), .o_rd_re(s_rd_re), .o_rd_im(s_rd_im));

  int errors = 0, checks = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int     x1r[64], x1i[64], x2r[64], x2i[64];
  longint m_re[NL], m_im[NL], m_mag;
  int     m_idx;

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void model(input int len);
    longint mag;
    for (int k = 0; k < NL; k++) begin
      m_re[k] = 0;
      m_im[k] = 0;
      for (int n = k; n < len; n++) begin
        m_re[k] += longint'(x1r[n-k])*x2r[n] + longint'(x1i[n-k])*x2i[n];
        m_im[k] += longint'(x1i[n-k])*x2r[n] - longint'(x1r[n-k])*x2i[n];
      end
    end
    m_idx = 0;
    m_mag = 0;
    for (int k = 0; k < NL; k++) begin
      mag = labs(m_re[k]) + labs(m_im[k]);
      if (mag > m_mag) begin
        m_mag = mag;
        m_idx = k;
      end
    end
  endfunction

  function automatic void clear_samples();
    for (int n = 0; n < 64; n++) begin
      x1r[n] = 0; x1i[n] = 0; x2r[n] = 0; x2i[n] = 0;
    end
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  function automatic void rand_samples();
    for (int n = 0; n < 64; n++) begin
      x1r[n] = rnd16(); x1i[n] = rnd16(); x2r[n] = rnd16(); x2i[n] = rnd16();
    end
  endfunction

  task automatic run_frame(input string name, input int len, input bit gaps, input bit poke);
    int n, lat, guard;
    bit toggle, accepted;
    model(len);
    @(negedge clk);
    i_start = 1'b1;
    i_frame_len = LW'(len);
    @(negedge clk);
    i_start = 1'b0;
    check({name, " busy"}, longint'(o_busy), 1);
    if (len > 0) begin
      n = 0; guard = 0; toggle = 1'b0;
      while (n < len && guard < 500) begin
        i_start = poke && (guard == 2);
        if (poke && guard == 2) i_frame_len = LW'(3);
        if (gaps && toggle) begin
          i_in_valid = 1'b0;
        end else begin
          i_in_valid = 1'b1;
          i_x1_re = DW'(x1r[n]); i_x1_im = DW'(x1i[n]);
          i_x2_re = DW'(x2r[n]); i_x2_im = DW'(x2i[n]);
        end
        toggle = ~toggle;
        accepted = i_in_valid && o_in_ready;
        @(negedge clk);
        if (accepted) n++;
        guard++;
      end
      i_in_valid = 1'b0;
      i_start = 1'b0;
      check({name, " accepts"}, n, len);
      check({name, " in_ready drop"}, longint'(o_in_ready), 0);
      lat = 1;
    end else begin
      lat = 0;
    end
    while (!o_done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, lat, (len > 0) ? NL+3 : NL+1);
    check({name, " peak_index"}, longint'(o_peak_index), m_idx);
    check({name, " peak_mag"}, longint'(o_peak_mag), m_mag);
    check({name, " busy clear"}, longint'(o_busy), 0);
    @(negedge clk);
    check({name, " done pulse"}, longint'(o_done), 0);
    for (int k = 0; k < NL; k++) begin
      i_rd_lag = IW'(k);
      @(negedge clk);
      check($sformatf("%s rd_re[%0d]", name, k), o_rd_re, m_re[k]);
      check($sformatf("%s rd_im[%0d]", name, k), o_rd_im, m_im[k]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    longint sum, exp_s;
    repeat (2) @(negedge clk);
    check("rst busy", longint'(o_busy), 0);
    check("rst in_ready", longint'(o_in_ready), 0);
    check("rst done", longint'(o_done), 0);
    check("rst peak_mag", longint'(o_peak_mag), 0);
    rst = 1'b0;

    clear_samples();
    x1r[0] = 100; x2r[3] = 50;
    run_frame("impulse", 8, 1'b0, 1'b0);

    clear_samples();
    x1r[0] = 3; x1i[0] = 4; x2r[2] = 1;
    run_frame("cplx", 4, 1'b0, 1'b0);

    clear_samples();
    for (int n = 0; n < 8; n++) begin x1r[n] = 1; x2r[n] = 1; end
    run_frame("ones", 8, 1'b0, 1'b0);
    run_frame("ones gaps", 8, 1'b1, 1'b0);

    run_frame("len0", 0, 1'b0, 1'b0);

    rand_samples();
    run_frame("busy start", 10, 1'b0, 1'b1);

    for (int f = 0; f < 6; f++) begin
      rand_samples();
      run_frame($sformatf("rand%0d", f), int'($urandom_range(20, 1)), 1'(f % 2), 1'b0);
    end

    rand_samples();
    @(negedge clk);
    i_start = 1'b1;
    i_frame_len = LW'(8);
    @(negedge clk);
    i_start = 1'b0;
    i_in_valid = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst busy", longint'(o_busy), 0);
    check("midrst in_ready", longint'(o_in_ready), 0);
    check("midrst peak_mag", longint'(o_peak_mag), 0);
    check("midrst peak_index", longint'(o_peak_index), 0);
    check("midrst rd_re", o_rd_re, 0);
    i_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_done) seen++;
    end
    check("midrst no done", seen, 0);
    run_frame("after rst", 12, 1'b0, 1'b0);

    @(negedge clk);
    s_x1_re = 8'sd127;
    s_x2_re = 8'sd127;
    s_start = 1'b1;
    s_frame_len = LW'(17);
    s_in_valid = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    seen = 0;
    while (!s_done && seen < 300) begin
      @(negedge clk);
      seen++;
    end
    s_in_valid = 1'b0;
    check("small done", longint'(s_done), 1);
    s_rd_lag = '0;
    @(negedge clk);
    sum = 17 * 127 * 127;
`ifdef XCORR_SATURATE_EN
    exp_s = (sum > 131071) ? 131071 : sum;
`else
    exp_s = sum % 262144;
    if (exp_s >= 131072) exp_s -= 262144;
`endif
    check("small rd_re lag0", s_rd_re, exp_s);
    check("small rd_im lag0", s_rd_im, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
